// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the datapath/caches and pipe_ctrl.
// Valid/ready: no handshake here; every signal is a level sampled on each rising clk edge.
interface pipe_ctrl_if;
   logic pc_sel;
   logic icache_stall;
   logic dcache_stall;
   logic rwe_in;
   logic csr_we_in;
   logic pipe_en;
   logic flush_12;
   logic flush_23;
   logic rwe;
   logic csr_we;

   modport master (
      output pc_sel, icache_stall, dcache_stall, rwe_in, csr_we_in,
      input  pipe_en, flush_12, flush_23, rwe, csr_we
   );

   modport slave (
      input  pc_sel, icache_stall, dcache_stall, rwe_in, csr_we_in,
      output pipe_en, flush_12, flush_23, rwe, csr_we
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Three-stage pipeline controller: boot sequencing, stall freeze, redirect flush, hang watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles/flush_count performance counters.
module pipe_ctrl (
   input  logic          clk,
   input  logic          reset,
   pipe_ctrl_if.slave    bus,
   output logic [1:0]    state,
   output logic          hang,
   output logic [31:0]   stall_cycles,
   output logic [31:0]   flush_count
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      ISTALL = 2'd2,
      DSTALL = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  boot_cnt_q, boot_cnt_d;
   logic [7:0]  stall_cnt_q, stall_cnt_d;
   logic        hang_q, hang_d;
   logic        pend_q, pend_d;

   logic        in_boot;
   logic        pipe_en;
   logic        pc_flush;
   logic        stalled;

   always_comb begin
      in_boot  = (state_q == BOOT);
      pipe_en  = !reset && !in_boot && !bus.icache_stall && !bus.dcache_stall;
      // A redirect seen while frozen is remembered and applied on the first advance.
      pc_flush = pipe_en && (bus.pc_sel || pend_q);
      stalled  = !reset && !in_boot && !pipe_en;

      bus.pipe_en  = pipe_en;
      bus.flush_12 = reset || in_boot || pc_flush;
      bus.flush_23 = reset || in_boot || pc_flush;
      bus.rwe      = bus.rwe_in && pipe_en;
      bus.csr_we   = bus.csr_we_in && pipe_en;
   end

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      case (state_q)
         BOOT: begin
            if (boot_cnt_q == 2'd1) begin
               state_d = RUN;
            end else begin
               boot_cnt_d = boot_cnt_q + 2'd1;
            end
         end
         default: begin
            if (bus.dcache_stall) begin
               state_d = DSTALL;
            end else if (bus.icache_stall) begin
               state_d = ISTALL;
            end else begin
               state_d = RUN;
            end
         end
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      if (pipe_en) begin
         pend_d = 1'b0;
      end else if (!in_boot && bus.pc_sel) begin
         pend_d = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (pipe_en) begin
         stall_cnt_d = 8'd0;
      end else if (stalled && (stall_cnt_q != 8'hFF)) begin
         stall_cnt_d = stall_cnt_q + 8'd1;
      end

      hang_d = hang_q || (stall_cnt_d == 8'hFF);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= BOOT;
         boot_cnt_q  <= 2'd0;
         stall_cnt_q <= 8'd0;
         hang_q      <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         hang_q      <= hang_d;
         pend_q      <= pend_d;
      end
   end

   assign state = state_q;
   assign hang  = hang_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   // Both counters wrap naturally at 2^32.
   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, stalled};
      flush_count_d  = flush_count_q + {31'd0, pc_flush};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have pc_sel  in  1  Stage3 redirect: the stage-3 instruction jumps/branches taken.
REQ-004 SHALL have icache_stall  in  1  fetch not ready this cycle.
REQ-005 SHALL have dcache_stall  in  1  load/store not complete this cycle.
REQ-006 SHALL have rwe_in, csr_we_in  in  1 each  raw Stage3 register/CSR write enables.
REQ-007 SHALL have pipe_en  out  1  enable for PC, Transfer_1_2 and Transfer_2_3 registers.
REQ-008 SHALL have flush_12, flush_23  out  1 each  load a bubble (NOP) into the respective transfer register.
REQ-009 SHALL have rwe, csr_we  out  1 each  gated write enables to regfile/CSR.
REQ-010 SHALL have state  out  2  FSM state: BOOT=0, RUN=1, ISTALL=2, DSTALL=3.
REQ-011 SHALL have hang  out  1  sticky stall-timeout flag.
REQ-012 SHALL have stall_cycles, flush_count  out  32 each  performance counters.

Function
REQ-013 SHALL compute pipe_en = (state!=BOOT) & !icache_stall & !dcache_stall, combinationally.
REQ-014 SHALL drive rwe = rwe_in & pipe_en and csr_we = csr_we_in & pipe_en, so each instruction commits exactly once.
REQ-015 SHALL assert flush_12 and flush_23 when (pipe_en & pc_sel) or state==BOOT; both low otherwise.
REQ-016 SHALL keep pc_sel effective across stalls: a frozen pipeline holds pc_sel, and the flush fires in the first advancing cycle.
REQ-017 SHALL hold BOOT for exactly 2 cycles after reset deassertion (2-bit boot counter), then go to RUN.
REQ-018 SHALL, from RUN/ISTALL/DSTALL, go next to DSTALL if dcache_stall, else ISTALL if icache_stall, else RUN (dcache has priority on simultaneous stalls).
REQ-019 SHALL maintain an 8-bit consecutive-stall counter: +1 each cycle state!=BOOT and pipe_en==0, cleared when pipe_en==1.
REQ-020 SHALL set hang when the stall counter reaches 255; the counter saturates at 255, and hang stays set until reset.
REQ-021 SHALL ignore pc_sel, rwe_in and csr_we_in while in BOOT.

Reset
REQ-022 SHALL, on reset high at a clock edge, set state=BOOT, boot counter=0, stall counter=0, hang=0, and both performance counters=0.
REQ-023 SHALL, while reset is high, output pipe_en=0, flush_12=flush_23=1, rwe=csr_we=0; reset asserted mid-stall aborts the stall immediately.

Configuration
REQ-024 SHALL, with PIPE_CTRL_PERF_EN defined, count stall_cycles +1 per cycle with state!=BOOT & pipe_en==0, and flush_count +1 per pc_sel-induced flush; both wrap modulo 2^32.
REQ-025 SHALL, without PIPE_CTRL_PERF_EN, keep the stall_cycles and flush_count ports but tie them to 0 with no counter flops.

Verification
REQ-026 SHALL cover reset release with no stalls -> state 0,0 then 1; pipe_en first high on the 3rd cycle after reset low; flushes high for exactly 2 cycles.
REQ-027 SHALL cover dcache_stall for 5 cycles with rwe_in=1 -> state=3, pipe_en=0, rwe=0 for 5 cycles, then rwe=1 for one cycle; stall_cycles=5 (perf build).
REQ-028 SHALL cover icache_stall and dcache_stall raised together for 3 cycles -> state=3 (not 2).
REQ-029 SHALL cover pc_sel=1 during a 4-cycle icache_stall -> no flush during the stall, then flush_12=flush_23=1 in the single advancing cycle; flush_count=1.
REQ-030 SHALL cover dcache_stall held for 300 cycles -> hang rises at stall cycle 255 and stays high after the stall clears, until reset.
REQ-031 SHALL cover reset asserted on the 2nd cycle of a DSTALL -> next state=0, hang=0, and both counters=0.
